// File: rtl/voice_sequencer_pkg.sv
// Shared constants and types for the three-voice frame sequencer.
// Register map, CTRL bit positions, FSM state type and the per-voice parameter bundle.
package voice_sequencer_pkg;

  localparam int NUM_VOICES = 3;
  localparam int WAVE_W     = 10;

  localparam logic [2:0] REG_FREQ_LO = 3'd0;
  localparam logic [2:0] REG_FREQ_HI = 3'd1;
  localparam logic [2:0] REG_PW_LO   = 3'd2;
  localparam logic [2:0] REG_PW_HI   = 3'd3;
  localparam logic [2:0] REG_CTRL    = 3'd4;

  localparam int CTRL_WAVE_MSB = 7;
  localparam int CTRL_WAVE_LSB = 4;
  localparam int CTRL_RING_BIT = 2;
  localparam int CTRL_SYNC_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } seq_state_e;

  typedef struct packed {
    logic [15:0] freq;
    logic [11:0] pw;
    logic [3:0]  wave_sel;
    logic        sync;
    logic        ring;
  } voice_params_t;

endpackage

// File: rtl/voice_regfile.sv
// Live per-voice register file plus the frame shadow that feeds the generator.
// Shadow is loaded from the pre-write live values, so a same-cycle write lands next frame.
module voice_regfile
  import voice_sequencer_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [4:0]    addr_i,
  input  logic [7:0]    wdata_i,
  input  logic          snap_i,
  input  logic [1:0]    sel_i,
  output voice_params_t params_o
);

  voice_params_t live_q   [NUM_VOICES];
  voice_params_t shadow_q [NUM_VOICES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        live_q[v]   <= '0;
        shadow_q[v] <= '0;
      end
    end else begin
      if (snap_i) begin
        for (int v = 0; v < NUM_VOICES; v++) shadow_q[v] <= live_q[v];
      end
      // voice 3 and indices 5..7 match nothing and are dropped
      if (we_i) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (addr_i[4:3] == 2'(v)) begin
            case (addr_i[2:0])
              REG_FREQ_LO: live_q[v].freq[7:0]  <= wdata_i;
              REG_FREQ_HI: live_q[v].freq[15:8] <= wdata_i;
              REG_PW_LO:   live_q[v].pw[7:0]    <= wdata_i;
              REG_PW_HI:   live_q[v].pw[11:8]   <= wdata_i[3:0];
              REG_CTRL: begin
                live_q[v].wave_sel <= wdata_i[CTRL_WAVE_MSB:CTRL_WAVE_LSB];
                live_q[v].ring     <= wdata_i[CTRL_RING_BIT];
                live_q[v].sync     <= wdata_i[CTRL_SYNC_BIT];
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  always_comb begin
    params_o = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (sel_i == 2'(v)) params_o = shadow_q[v];
    end
  end

endmodule

// File: rtl/voice_sequencer.sv
// Frame sequencer: on each sample tick, runs the shared voice generator once per voice
// from a frozen parameter snapshot and collects the three samples for the mixer.
module voice_sequencer
  import voice_sequencer_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sample_tick_i,
  input  logic                     reg_we_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [7:0]               reg_wdata_i,
  output logic                     mv_start_o,
  output logic [1:0]               mv_voice_o,
  output logic [15:0]              mv_freq_o,
  output logic [11:0]              mv_pw_o,
  output logic [3:0]               mv_wave_sel_o,
  output logic                     mv_sync_o,
  output logic                     mv_ring_o,
  input  logic                     mv_ready_i,
  input  logic signed [WAVE_W-1:0] mv_wave_i,
  output logic signed [WAVE_W-1:0] voice0_o,
  output logic signed [WAVE_W-1:0] voice1_o,
  output logic signed [WAVE_W-1:0] voice2_o,
  output logic                     frame_valid_o,
  output logic                     overrun_o,
  output logic                     timeout_err_o
);

  seq_state_e    state_q, state_d;
  logic [1:0]    voice_q, voice_d;
  logic [3:0]    wd_q;
  logic [NUM_VOICES-1:0][WAVE_W-1:0] samp_q;
  logic          overrun_q;
  logic          timeout_q;
  voice_params_t params;

  logic accept, ready_ok, wd_expire, step;

  assign accept    = (state_q == ST_IDLE) && sample_tick_i;
  assign ready_ok  = (state_q == ST_WAIT) && mv_ready_i;
  assign wd_expire = (state_q == ST_WAIT) && !mv_ready_i && (wd_q == 4'hF);
  assign step      = ready_ok || wd_expire;

  voice_regfile u_regfile (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (reg_we_i),
    .addr_i   (reg_addr_i),
    .wdata_i  (reg_wdata_i),
    .snap_i   (accept),
    .sel_i    (voice_q),
    .params_o (params)
  );

  always_comb begin
    state_d = state_q;
    voice_d = voice_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_tick_i) begin
          state_d = ST_ISSUE;
          voice_d = 2'd0;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (step) begin
          if (voice_q == 2'(NUM_VOICES - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            voice_d = voice_q + 2'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      voice_q   <= 2'd0;
      wd_q      <= 4'd0;
      samp_q    <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      voice_q   <= voice_d;
      overrun_q <= sample_tick_i && (state_q != ST_IDLE);
      if (state_q == ST_ISSUE)     wd_q <= 4'd0;
      else if (state_q == ST_WAIT) wd_q <= wd_q + 4'd1;
      // a silent generator leaves a zero sample rather than a stale one
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (step && voice_q == 2'(v)) samp_q[v] <= ready_ok ? mv_wave_i : '0;
      end
      if (wd_expire) timeout_q <= 1'b1;
    end
  end

  assign mv_start_o    = (state_q == ST_ISSUE);
  assign mv_voice_o    = voice_q;
  assign mv_freq_o     = params.freq;
  assign mv_pw_o       = params.pw;
  assign mv_wave_sel_o = params.wave_sel;
  assign mv_sync_o     = params.sync;
  assign mv_ring_o     = params.ring;
  assign voice0_o      = samp_q[0];
  assign voice1_o      = samp_q[1];
  assign voice2_o      = samp_q[2];
  assign frame_valid_o = (state_q == ST_DONE);
  assign overrun_o     = overrun_q;
  assign timeout_err_o = timeout_q;

endmodule

// File: tb/tb_voice_sequencer.sv
// Directed bench for voice_sequencer with a fixed-latency generator responder.
module tb_voice_sequencer;
  import voice_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_tick = 1'b0;
  logic reg_we = 1'b0;
  logic [4:0] reg_addr = '0;
  logic [7:0] reg_wdata = '0;
  logic mv_start, mv_sync, mv_ring, mv_ready;
  logic [1:0] mv_voice;
  logic [15:0] mv_freq;
  logic [11:0] mv_pw;
  logic [3:0] mv_wave_sel;
  logic signed [9:0] mv_wave, voice0, voice1, voice2;
  logic frame_valid, overrun, timeout_err;

  always #10 clk = ~clk;

  voice_sequencer dut (
    .clk_i(clk), .rst_i(rst), .sample_tick_i(sample_tick),
    .reg_we_i(reg_we), .reg_addr_i(reg_addr), .reg_wdata_i(reg_wdata),
    .mv_start_o(mv_start), .mv_voice_o(mv_voice), .mv_freq_o(mv_freq),
    .mv_pw_o(mv_pw), .mv_wave_sel_o(mv_wave_sel), .mv_sync_o(mv_sync),
    .mv_ring_o(mv_ring), .mv_ready_i(mv_ready), .mv_wave_i(mv_wave),
    .voice0_o(voice0), .voice1_o(voice1), .voice2_o(voice2),
    .frame_valid_o(frame_valid), .overrun_o(overrun), .timeout_err_o(timeout_err)
  );

  // generator model: done pulse 3 cycles after it samples start
  logic [9:0] resp [4];
  logic       silent [4];
  int rcnt = 0;
  always @(posedge clk) begin
    if (mv_start) rcnt <= 4;
    else if (rcnt != 0) rcnt <= rcnt - 1;
  end
  assign mv_ready = (rcnt == 1) && !silent[mv_voice];
  assign mv_wave  = resp[mv_voice];

  int start_cnt = 0, fv_cnt = 0, ovr_cnt = 0;
  logic [1:0]  log_voice [64];
  logic [15:0] log_freq [64];
  logic [11:0] log_pw [64];
  logic [3:0]  log_wave [64];
  logic        log_sync [64];
  logic        log_ring [64];
  logic [9:0]  fv_v0, fv_v1, fv_v2;

  always @(negedge clk) begin
    if (mv_start && start_cnt < 64) begin
      log_voice[start_cnt] = mv_voice;
      log_freq[start_cnt]  = mv_freq;
      log_pw[start_cnt]    = mv_pw;
      log_wave[start_cnt]  = mv_wave_sel;
      log_sync[start_cnt]  = mv_sync;
      log_ring[start_cnt]  = mv_ring;
      start_cnt++;
    end
    if (frame_valid) begin
      fv_cnt++;
      fv_v0 = voice0; fv_v1 = voice1; fv_v2 = voice2;
    end
    if (overrun) ovr_cnt++;
  end

  int total = 0, passed = 0, failed = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] out_vec();
    return {10'd0, mv_start, mv_voice, mv_freq, mv_pw, mv_wave_sel, mv_sync, mv_ring,
            voice0, voice1, voice2, frame_valid, overrun, timeout_err};
  endfunction

  task automatic wr(input logic [1:0] v, input logic [2:0] idx, input logic [7:0] d);
    @(negedge clk);
    reg_we = 1'b1; reg_addr = {v, idx}; reg_wdata = d;
    @(negedge clk);
    reg_we = 1'b0;
  endtask

  logic [15:0] freq_mid;
  logic [79:0] rst_snap;

  // one tick then 60 cycles; optional second tick, voice0 FREQ_LO write, reset pulse
  task automatic run_frame(input int tick2_at, input int wr_at, input int rst_at, output int lat);
    lat = -1;
    @(negedge clk);
    sample_tick = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      sample_tick = (n == tick2_at);
      reg_we      = (n == wr_at);
      reg_addr    = {2'd0, REG_FREQ_LO};
      reg_wdata   = 8'hAB;
      rst         = (n == rst_at);
      if (wr_at > 0 && n == wr_at + 2) freq_mid = mv_freq;
      if (rst_at > 0 && n == rst_at + 1) rst_snap = out_vec();
      if (frame_valid && lat < 0) lat = n;
    end
    sample_tick = 1'b0; reg_we = 1'b0; rst = 1'b0;
  endtask

  int lat, sb, fb, ob;

  initial begin
    for (int i = 0; i < 4; i++) begin resp[i] = '0; silent[i] = 1'b0; end
    repeat (2) @(negedge clk);
    check("reset_outputs", out_vec(), 80'd0);
    rst = 1'b0;

    wr(2'd1, REG_FREQ_LO, 8'h34);
    wr(2'd1, REG_FREQ_HI, 8'h12);
    wr(2'd1, REG_PW_LO,   8'h00);
    wr(2'd1, REG_PW_HI,   8'h08);
    wr(2'd1, REG_CTRL,    8'h20);
    wr(2'd2, REG_CTRL,    8'h16);
    wr(2'd0, REG_FREQ_LO, 8'h11);
    wr(2'd3, REG_FREQ_LO, 8'hFF);

    // frame 1: basic sequence
    resp[0] = 10'h200; resp[1] = 10'h000; resp[2] = 10'h1FF;
    sb = start_cnt; fb = fv_cnt; ob = ovr_cnt;
    run_frame(0, 0, 0, lat);
    check("f1_latency", 80'(lat), 80'd16);
    check("f1_starts", 80'(start_cnt - sb), 80'd3);
    check("f1_voice_order", {74'd0, log_voice[sb], log_voice[sb+1], log_voice[sb+2]}, {74'd0, 6'b00_01_10});
    check("f1_v1_params", {48'd0, log_freq[sb+1], log_pw[sb+1], log_wave[sb+1]}, {48'd0, 16'h1234, 12'h800, 4'b0010});
    check("f1_v2_ctrl", {74'd0, log_wave[sb+2], log_sync[sb+2], log_ring[sb+2]}, {74'd0, 4'b0001, 1'b1, 1'b1});
    check("f1_v0_freq", 80'(log_freq[sb]), 80'h0011);
    check("f1_samples", {50'd0, fv_v0, fv_v1, fv_v2}, {50'd0, 10'h200, 10'h000, 10'h1FF});
    check("f1_frames", 80'(fv_cnt - fb), 80'd1);
    check("f1_overruns", 80'(ovr_cnt - ob), 80'd0);

    // frame 2: live write in voice0 WAIT plus a dropped second tick
    sb = start_cnt; fb = fv_cnt; ob = ovr_cnt;
    run_frame(5, 2, 0, lat);
    check("f2_freq_held", 80'(freq_mid), 80'h0011);
    check("f2_latency", 80'(lat), 80'd16);
    check("f2_overruns", 80'(ovr_cnt - ob), 80'd1);
    check("f2_frames", 80'(fv_cnt - fb), 80'd1);
    check("f2_starts", 80'(start_cnt - sb), 80'd3);

    // frame 3: new FREQ_LO takes effect
    sb = start_cnt;
    run_frame(0, 0, 0, lat);
    check("f3_v0_freq", 80'(log_freq[sb]), 80'h00AB);
    check("f3_v1_freq", 80'(log_freq[sb+1]), 80'h1234);

    // frame 4: generator silent on voice2
    resp[0] = 10'd37; resp[1] = 10'h3FD; resp[2] = 10'd200; silent[2] = 1'b1;
    fb = fv_cnt;
    run_frame(0, 0, 0, lat);
    check("f4_latency", 80'(lat), 80'd28);
    check("f4_samples", {50'd0, fv_v0, fv_v1, fv_v2}, {50'd0, 10'd37, 10'h3FD, 10'd0});
    check("f4_frames", 80'(fv_cnt - fb), 80'd1);
    check("f4_timeout", 80'(timeout_err), 80'd1);

    // frame 5: normal frame, timeout flag stays set
    silent[2] = 1'b0;
    run_frame(0, 0, 0, lat);
    check("f5_latency", 80'(lat), 80'd16);
    check("f5_v2", 80'(fv_v2), 80'd200);
    check("f5_timeout_held", 80'(timeout_err), 80'd1);

    // frame 6: reset during voice1 WAIT
    fb = fv_cnt;
    run_frame(0, 0, 7, lat);
    check("f6_no_frame", 80'(fv_cnt - fb), 80'd0);
    check("f6_outputs_zero", rst_snap, 80'd0);
    check("f6_timeout_cleared", 80'(timeout_err), 80'd0);

    // frame 7: clean frame after reset, registers back to zero
    resp[0] = 10'd100; resp[1] = 10'h3FF; resp[2] = 10'h2D4;
    sb = start_cnt; fb = fv_cnt;
    run_frame(0, 0, 0, lat);
    check("f7_latency", 80'(lat), 80'd16);
    check("f7_frames", 80'(fv_cnt - fb), 80'd1);
    check("f7_v1_freq", 80'(log_freq[sb+1]), 80'd0);
    check("f7_samples", {50'd0, fv_v0, fv_v1, fv_v2}, {50'd0, 10'd100, 10'h3FF, 10'h2D4});
    check("f7_timeout", 80'(timeout_err), 80'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
